// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared widths, memory/ALU op codes, FSM states, op decoders
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int MEM_OP_W   = 4;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_e;

    // Unlisted op codes decode as SZ_NONE and therefore behave as pass-through.
    function automatic mem_size_e op_size(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: op_size = SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: op_size = SZ_HALF;
            MEM_LW, MEM_SW:          op_size = SZ_WORD;
            default:                 op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
        op_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
        op_is_load = (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
                     (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic addr_misaligned(input mem_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: addr_misaligned = off[0];
            SZ_WORD: addr_misaligned = (off != 2'b00);
            default: addr_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// mem_load_align : shifts the bus read word down to the addressed lane and
//                  sign/zero-extends it according to the load type
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op,
    input  logic [1:0]          byte_off,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        data = rdata;
        case (op)
            MEM_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: data = {24'd0, shifted[7:0]};
            MEM_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline memory stage; issues one data-bus access per load/store
//             and stalls upstream until the bus acknowledges it
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_des_addr_in,
    input  logic                  ex_des_exist_in,
    input  logic [DATA_W-1:0]     ex_des_data_in,
    input  logic [MEM_OP_W-1:0]   ex_mem_op_in,
    input  logic [DATA_W-1:0]     ex_mem_addr_in,
    input  logic [DATA_W-1:0]     ex_mem_wdata_in,
    output logic                  bus_req_out,
    output logic                  bus_we_out,
    output logic [DATA_W-1:0]     bus_addr_out,
    output logic [BE_W-1:0]       bus_be_out,
    output logic [DATA_W-1:0]     bus_wdata_out,
    input  logic                  bus_ack_in,
    input  logic [DATA_W-1:0]     bus_rdata_in,
    output logic                  stall_req_out,
    output logic                  mem_misalign_out,
    output logic [REG_ADDR_W-1:0] wb_des_addr_out,
    output logic                  wb_des_exist_out,
    output logic [DATA_W-1:0]     wb_des_data_out
);

    state_e                state;
    state_e                next_state;

    mem_size_e             size;
    logic                  is_mem;
    logic                  misaligned;
    logic                  accept_mem;
    logic [BE_W-1:0]       be_next;
    logic [DATA_W-1:0]     wdata_next;

    // Context of the in-flight access, needed when the ack arrives.
    logic [REG_ADDR_W-1:0] lat_des;
    logic [MEM_OP_W-1:0]   lat_op;
    logic [1:0]            lat_off;
    logic [DATA_W-1:0]     load_data;

    assign size       = op_size(ex_mem_op_in);
    assign is_mem     = (size != SZ_NONE);
    assign misaligned = is_mem && addr_misaligned(size, ex_mem_addr_in[1:0]);
    assign accept_mem = is_mem && !misaligned;

    assign stall_req_out = (state == ST_BUSY);

    always_comb begin
        be_next    = '0;
        wdata_next = ex_mem_wdata_in;
        case (size)
            SZ_BYTE: begin
                be_next    = 4'b0001 << ex_mem_addr_in[1:0];
                wdata_next = {4{ex_mem_wdata_in[7:0]}};
            end
            SZ_HALF: begin
                be_next    = 4'b0011 << {ex_mem_addr_in[1], 1'b0};
                wdata_next = {2{ex_mem_wdata_in[15:0]}};
            end
            SZ_WORD: be_next = 4'b1111;
            default: be_next = '0;
        endcase
    end

    mem_load_align u_load_align (
        .op       (lat_op),
        .byte_off (lat_off),
        .rdata    (bus_rdata_in),
        .data     (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept_mem) next_state = ST_BUSY;
            ST_BUSY: if (bus_ack_in) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_out      <= 1'b0;
            bus_we_out       <= 1'b0;
            bus_addr_out     <= '0;
            bus_be_out       <= '0;
            bus_wdata_out    <= '0;
            mem_misalign_out <= 1'b0;
            wb_des_addr_out  <= '0;
            wb_des_exist_out <= 1'b0;
            wb_des_data_out  <= '0;
            lat_des          <= '0;
            lat_op           <= '0;
            lat_off          <= '0;
        end else begin
            mem_misalign_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_mem) begin
                        bus_req_out      <= 1'b1;
                        bus_we_out       <= op_is_store(ex_mem_op_in);
                        bus_addr_out     <= {ex_mem_addr_in[DATA_W-1:2], 2'b00};
                        bus_be_out       <= be_next;
                        bus_wdata_out    <= wdata_next;
                        lat_des          <= ex_des_addr_in;
                        lat_op           <= ex_mem_op_in;
                        lat_off          <= ex_mem_addr_in[1:0];
                        wb_des_exist_out <= 1'b0;
                    end else if (misaligned) begin
                        bus_req_out      <= 1'b0;
                        mem_misalign_out <= 1'b1;
                        wb_des_exist_out <= 1'b0;
                    end else begin
                        bus_req_out      <= 1'b0;
                        wb_des_addr_out  <= ex_des_addr_in;
                        wb_des_exist_out <= ex_des_exist_in;
                        wb_des_data_out  <= ex_des_data_in;
                    end
                end
                ST_BUSY: begin
                    // Bus fields hold their values until the ack edge.
                    wb_des_exist_out <= 1'b0;
                    if (bus_ack_in) begin
                        bus_req_out <= 1'b0;
                        if (op_is_load(lat_op)) begin
                            wb_des_addr_out  <= lat_des;
                            wb_des_exist_out <= 1'b1;
                            wb_des_data_out  <= load_data;
                        end
                    end
                end
                default: bus_req_out <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed and randomized bench for mem_stage with a
//                transaction-level expectation queue
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ex_des_addr_in;
    logic        ex_des_exist_in;
    logic [31:0] ex_des_data_in;
    logic [3:0]  ex_mem_op_in;
    logic [31:0] ex_mem_addr_in;
    logic [31:0] ex_mem_wdata_in;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [3:0]  bus_be_out;
    logic [31:0] bus_wdata_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;
    logic        stall_req_out;
    logic        mem_misalign_out;
    logic [4:0]  wb_des_addr_out;
    logic        wb_des_exist_out;
    logic [31:0] wb_des_data_out;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_des_addr_in   (ex_des_addr_in),
        .ex_des_exist_in  (ex_des_exist_in),
        .ex_des_data_in   (ex_des_data_in),
        .ex_mem_op_in     (ex_mem_op_in),
        .ex_mem_addr_in   (ex_mem_addr_in),
        .ex_mem_wdata_in  (ex_mem_wdata_in),
        .bus_req_out      (bus_req_out),
        .bus_we_out       (bus_we_out),
        .bus_addr_out     (bus_addr_out),
        .bus_be_out       (bus_be_out),
        .bus_wdata_out    (bus_wdata_out),
        .bus_ack_in       (bus_ack_in),
        .bus_rdata_in     (bus_rdata_in),
        .stall_req_out    (stall_req_out),
        .mem_misalign_out (mem_misalign_out),
        .wb_des_addr_out  (wb_des_addr_out),
        .wb_des_exist_out (wb_des_exist_out),
        .wb_des_data_out  (wb_des_data_out)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          stall;
        bit          mis;
        logic [4:0]  wa;
        bit          wx;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    exp_t ce;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " bus_req"},   32'(bus_req_out),      32'd0);
        chk({tag, " bus_we"},    32'(bus_we_out),       32'd0);
        chk({tag, " bus_addr"},  bus_addr_out,          32'd0);
        chk({tag, " bus_be"},    32'(bus_be_out),       32'd0);
        chk({tag, " bus_wdata"}, bus_wdata_out,         32'd0);
        chk({tag, " stall"},     32'(stall_req_out),    32'd0);
        chk({tag, " misalign"},  32'(mem_misalign_out), 32'd0);
        chk({tag, " wb_addr"},   32'(wb_des_addr_out),  32'd0);
        chk({tag, " wb_exist"},  32'(wb_des_exist_out), 32'd0);
        chk({tag, " wb_data"},   wb_des_data_out,       32'd0);
    endtask

    // ---------------- behavioural model (spec rules as arithmetic) ----------
    function automatic int m_bytes(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (op)
            MEM_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            MEM_LBU: v = v % 256;
            MEM_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            MEM_LHU: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] w);
        if (n == 1) return (w % 256) * 32'h0101_0101;
        if (n == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic exp_t e_pass(input logic [4:0] a, input bit x, input logic [31:0] d);
        exp_t e;
        e = '{default: '0};
        e.wa = a; e.wx = x; e.wd = d;
        return e;
    endfunction

    function automatic exp_t e_mis();
        exp_t e;
        e = '{default: '0};
        e.mis = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_busy(input bit we, input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd);
        exp_t e;
        e = '{default: '0};
        e.req = 1'b1; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.stall = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_done(input bit ld, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e = '{default: '0};
        e.wx = ld; e.wa = a; e.wd = d;
        return e;
    endfunction

    // ---------------- stimulus ----------------------------------------------
    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] des, input bit dex, input logic [31:0] dd,
                       input int waitc, input logic [31:0] rd,
                       input exp_t first, input bit is_mem, input exp_t fin);
        ex_mem_op_in    = op;
        ex_mem_addr_in  = addr;
        ex_mem_wdata_in = wd;
        ex_des_addr_in  = des;
        ex_des_exist_in = dex;
        ex_des_data_in  = dd;
        bus_ack_in      = 1'($urandom % 2);
        bus_rdata_in    = $urandom;
        step(first);
        if (is_mem) begin
            for (int k = 0; k <= waitc; k++) begin
                ex_mem_op_in    = 4'($urandom_range(0, 8));
                ex_mem_addr_in  = $urandom;
                ex_mem_wdata_in = $urandom;
                ex_des_addr_in  = 5'($urandom);
                ex_des_exist_in = 1'($urandom);
                ex_des_data_in  = $urandom;
                bus_ack_in      = (k == waitc);
                bus_rdata_in    = (k == waitc) ? rd : $urandom;
                if (k == waitc) step(fin);
                else            step(first);
            end
        end
        bus_ack_in = 1'b0;
    endtask

    task automatic model_run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] des, input bit dex, input logic [31:0] dd,
                             input int waitc, input logic [31:0] rd);
        int   n;
        exp_t f;
        exp_t d;
        bit   mem;
        n   = m_bytes(op);
        d   = e_pass(des, dex, dd);
        mem = 1'b0;
        if (n == 0) begin
            f = e_pass(des, dex, dd);
        end else if (addr % n != 0) begin
            f = e_mis();
        end else begin
            f   = e_busy(m_store(op), addr - addr % 4, m_be(n, addr), m_wdata(n, wd));
            d   = e_done(!m_store(op), des, m_load(op, addr, rd));
            mem = 1'b1;
        end
        run(op, addr, wd, des, dex, dd, waitc, rd, f, mem, d);
    endtask

    // ---------------- compare process ---------------------------------------
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            ce = q.pop_front();
            chk("bus_req",  32'(bus_req_out),      32'(ce.req));
            chk("stall",    32'(stall_req_out),    32'(ce.stall));
            chk("misalign", 32'(mem_misalign_out), 32'(ce.mis));
            chk("wb_exist", 32'(wb_des_exist_out), 32'(ce.wx));
            if (ce.req) begin
                chk("bus_we",   32'(bus_we_out), 32'(ce.we));
                chk("bus_addr", bus_addr_out,    ce.addr);
                chk("bus_be",   32'(bus_be_out), 32'(ce.be));
                if (ce.we) chk("bus_wdata", bus_wdata_out, ce.wdata);
            end
            if (ce.wx) begin
                chk("wb_addr", 32'(wb_des_addr_out), 32'(ce.wa));
                chk("wb_data", wb_des_data_out,      ce.wd);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;

        ex_des_addr_in  = '0;
        ex_des_exist_in = 1'b0;
        ex_des_data_in  = '0;
        ex_mem_op_in    = MEM_NONE;
        ex_mem_addr_in  = '0;
        ex_mem_wdata_in = '0;
        bus_ack_in      = 1'b0;
        bus_rdata_in    = '0;

        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Pass-through with literal expectations.
        run(MEM_NONE, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678, 0, 32'h0,
            e_pass(5'd3, 1'b1, 32'h1234_5678), 1'b0, e_pass(5'd3, 1'b1, 32'h1234_5678));
        // lb at 0x103, ack on second BUSY cycle.
        run(MEM_LB, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 32'h0, 1, 32'h8000_0000,
            e_busy(1'b0, 32'h0000_0100, 4'b1000, 32'h0), 1'b1,
            e_done(1'b1, 5'd5, 32'hFFFF_FF80));
        // sh at 0x22 with immediate ack.
        run(MEM_SH, 32'h0000_0022, 32'h0000_ABCD, 5'd9, 1'b0, 32'h0, 0, 32'h0,
            e_busy(1'b1, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD), 1'b1,
            e_done(1'b0, 5'd0, 32'h0));
        // Misaligned lw, then a bubble to prove the pulse lasts one cycle.
        run(MEM_LW, 32'h0000_0006, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h0,
            e_mis(), 1'b0, e_mis());
        run(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 0, 32'h0,
            e_pass(5'd0, 1'b0, 32'h0), 1'b0, e_pass(5'd0, 1'b0, 32'h0));

        // Reset while an lhu is outstanding, then a stray ack.
        ex_mem_op_in    = MEM_LHU;
        ex_mem_addr_in  = 32'h0000_0042;
        ex_des_addr_in  = 5'd7;
        ex_des_exist_in = 1'b1;
        bus_ack_in      = 1'b0;
        step(e_busy(1'b0, 32'h0000_0040, 4'b1100, 32'h0));
        ex_mem_op_in    = MEM_NONE;
        ex_des_addr_in  = 5'd0;
        ex_des_exist_in = 1'b0;
        ex_des_data_in  = 32'h0;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 chk("rst_hold stall", 32'(stall_req_out), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus_ack_in   = 1'b1;
        bus_rdata_in = 32'hDEAD_BEEF;
        step(e_pass(5'd0, 1'b0, 32'h0));
        bus_ack_in = 1'b0;
        step(e_pass(5'd0, 1'b0, 32'h0));

        // Randomized traffic against the model.
        repeat (200) begin
            a = $urandom;
            r = $urandom_range(0, 3);
            if (r == 1 || r == 3) a[1:0] = 2'b00;
            if (r == 2)           a[0]   = 1'b0;
            model_run(4'($urandom_range(0, 8)), a, $urandom, 5'($urandom), 1'($urandom),
                      $urandom, $urandom_range(0, 3), $urandom);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
